// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: FSM states, engine opcodes and fixed-point constants for cordic_sched
package cordic_sched_pkg;
    typedef enum logic [3:0] {
        IDLE, ROT_ISSUE, ROT_WAIT, RDX_ISSUE, RDX_WAIT, RDY_ISSUE, RDY_WAIT, ABORT, RESP
    } state_t;
    localparam logic [7:0] OP_ROT = 8'd0;
    localparam logic [7:0] OP_RDX = 8'd1;
    localparam logic [7:0] OP_RDY = 8'd2;
    localparam int ANGLE_PI_2 = 421657428;
    localparam int Q428_ONE = 268435456;
    localparam int TMR_W = 8;
endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick starting just after the last grant
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    int k;
    // Scan from farthest to nearest so the nearest requester after last_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        k = 0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(last_i) + i) % NREQ;
            if (en_i && req_i[k]) begin
                gnt_o = '0;
                gnt_o[k] = 1'b1;
                idx_o = IW'(k);
            end
        end
    end
endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: shares one CORDIC engine between NREQ requesters, sequencing rotate/read X/read Y
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int ANGLE_MAX = ANGLE_PI_2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_angle,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_cos,
    output logic [31:0]        rsp_sin,
    output logic               rsp_err,
    output logic               eng_clk_en,
    output logic               eng_rst,
    output logic               eng_start,
    output logic [7:0]         eng_n,
    output logic [31:0]        eng_dataa,
    input  logic               eng_done,
    input  logic [31:0]        eng_result
);
    localparam int IW = $clog2(NREQ);
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;
    logic [IW-1:0] last_q, last_d, id_q, id_d, gidx;
    logic [31:0] angle_q, angle_d, cos_q, cos_d, sel_angle;
    logic [31:0] rsp_cos_q, rsp_cos_d, rsp_sin_q, rsp_sin_d;
    logic rsp_err_q, rsp_err_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [NREQ-1:0] gnt;
    logic [32:0] mag;
    logic too_big, is_wait, expired;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i(req_valid), .en_i(state_q == IDLE && !reset), .last_i(last_q),
        .gnt_o(gnt), .idx_o(gidx)
    );

    // 33-bit magnitude so 0x80000000 cannot wrap back into range.
    assign sel_angle = req_angle[gidx*32 +: 32];
    assign mag = sel_angle[31] ? 33'd0 - {1'b1, sel_angle} : {1'b0, sel_angle};
    assign too_big = mag > 33'(ANGLE_MAX);
    assign is_wait = state_q inside {ROT_WAIT, RDX_WAIT, RDY_WAIT};
    assign expired = tmr_q == TO_LAST;

    always_comb begin
        state_d = state_q;
        last_d = last_q;
        id_d = id_q;
        angle_d = angle_q;
        cos_d = cos_q;
        rsp_cos_d = rsp_cos_q;
        rsp_sin_d = rsp_sin_q;
        rsp_err_d = rsp_err_q;
        tmr_d = is_wait ? tmr_q + TMR_W'(1) : '0;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = too_big ? RESP : ROT_ISSUE;
                last_d = gidx;
                id_d = gidx;
                angle_d = sel_angle;
                if (too_big) {rsp_cos_d, rsp_sin_d, rsp_err_d} = {64'd0, 1'b1};
            end
            ROT_ISSUE: state_d = ROT_WAIT;
            ROT_WAIT:  state_d = eng_done ? RDX_ISSUE : expired ? ABORT : ROT_WAIT;
            RDX_ISSUE: state_d = RDX_WAIT;
            RDX_WAIT: begin
                state_d = eng_done ? RDY_ISSUE : expired ? ABORT : RDX_WAIT;
                if (eng_done) cos_d = eng_result;
            end
            RDY_ISSUE: state_d = RDY_WAIT;
            RDY_WAIT: begin
                state_d = eng_done ? RESP : expired ? ABORT : RDY_WAIT;
                if (eng_done) {rsp_cos_d, rsp_sin_d, rsp_err_d} = {cos_q, eng_result, 1'b0};
            end
            ABORT: begin
                state_d = RESP;
                cos_d = '0;
                {rsp_cos_d, rsp_sin_d, rsp_err_d} = {64'd0, 1'b1};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q <= IW'(NREQ - 1);
            id_q <= '0;
            angle_q <= '0;
            cos_q <= '0;
            tmr_q <= '0;
            rsp_cos_q <= '0;
            rsp_sin_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            angle_q <= angle_d;
            cos_q <= cos_d;
            tmr_q <= tmr_d;
            rsp_cos_q <= rsp_cos_d;
            rsp_sin_q <= rsp_sin_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == RESP) ? NREQ'(1) << id_q : '0;
    assign rsp_cos = rsp_cos_q;
    assign rsp_sin = rsp_sin_q;
    assign rsp_err = rsp_err_q;
    assign eng_clk_en = state_q != IDLE;
    assign eng_rst = reset | (state_q == ABORT);
    assign eng_start = state_q inside {ROT_ISSUE, RDX_ISSUE, RDY_ISSUE};
    assign eng_n = (state_q == RDX_ISSUE) ? OP_RDX : (state_q == RDY_ISSUE) ? OP_RDY : OP_ROT;
    assign eng_dataa = (state_q == ROT_ISSUE) ? angle_q : '0;
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed vectors against a behavioural CORDIC engine (22-cycle rotate, 1-cycle reads)
module tb_cordic_sched;
    localparam int NREQ = 2;

    logic clk = 1'b0, reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [32*NREQ-1:0] req_angle = '0;
    logic [NREQ-1:0] req_ready, rsp_valid;
    logic [31:0] rsp_cos, rsp_sin, eng_dataa, eng_result;
    logic rsp_err, eng_clk_en, eng_rst, eng_start, eng_done;
    logic [7:0] eng_n;
    logic stub = 1'b0, stray = 1'b0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cordic_sched #(.NREQ(NREQ), .TIMEOUT_CYC(64), .ANGLE_MAX(421657428)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .rsp_err(rsp_err), .eng_clk_en(eng_clk_en), .eng_rst(eng_rst), .eng_start(eng_start),
        .eng_n(eng_n), .eng_dataa(eng_dataa), .eng_done(eng_done), .eng_result(eng_result)
    );

    function automatic int qtrig(input logic [31:0] a, input bit s);
        real r;
        r = $itor($signed(a)) / 268435456.0;
        return $rtoi((s ? $sin(r) : $cos(r)) * 268435456.0);
    endfunction

    // Engine model: done is combinational from its own state, frozen while clk_en is low.
    logic pend = 1'b0;
    int cnt = 0, ex = 0, ey = 0;
    logic [7:0] op = 8'd0;
    always @(posedge clk) begin
        if (eng_rst) begin
            pend <= 1'b0;
            cnt <= 0;
        end else if (eng_clk_en) begin
            if (eng_start) begin
                pend <= 1'b1;
                op <= eng_n;
                cnt <= (eng_n == 8'd0) ? 21 : 0;
                if (eng_n == 8'd0) begin
                    ex <= qtrig(eng_dataa, 1'b0);
                    ey <= qtrig(eng_dataa, 1'b1);
                end
            end else if (pend && cnt != 0) cnt <= cnt - 1;
            else pend <= 1'b0;
        end
    end
    assign eng_done = (pend && cnt == 0 && !stub) || stray;
    assign eng_result = eng_done ? ((op == 8'd1) ? ex : ey) : 32'd0;

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = '0;
        oh[i] = 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input int exp);
        n_chk++;
        if (act > exp + 1024 || act < exp - 1024) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +-1024", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string p);
        chk({p, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({p, "_rsp_cos"}, 64'(rsp_cos), 64'd0);
        chk({p, "_rsp_sin"}, 64'(rsp_sin), 64'd0);
        chk({p, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({p, "_eng_start"}, 64'(eng_start), 64'd0);
        chk({p, "_eng_n"}, 64'(eng_n), 64'd0);
        chk({p, "_eng_dataa"}, 64'(eng_dataa), 64'd0);
        chk({p, "_eng_clk_en"}, 64'(eng_clk_en), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_eng_rst", 64'(eng_rst), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_one(input string nm, input int id, input logic [31:0] ang,
                           input logic err, input int c, input int s, input int lat);
        int n;
        logic started;
        @(negedge clk);
        req_angle[id*32 +: 32] = ang;
        req_valid = oh(id);
        #1 chk({nm, "_ready"}, 64'(req_ready), 64'(oh(id)));
        @(negedge clk);
        req_valid = '0;
        n = 1;
        started = 1'b0;
        while (rsp_valid == '0 && n < 200) begin
            started |= eng_start;
            @(negedge clk);
            n++;
        end
        started |= eng_start;
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(oh(id)));
        chk({nm, "_err"}, 64'(rsp_err), 64'(err));
        chk_near({nm, "_cos"}, $signed(rsp_cos), c);
        chk_near({nm, "_sin"}, $signed(rsp_sin), s);
        if (err) chk({nm, "_no_start"}, 64'(started), 64'd0);
    endtask

    typedef struct {
        logic [31:0] ang;
        int id;
        logic err;
        int c;
        int s;
        int lat;
    } vec_t;
    vec_t v[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic any;
        int g_cyc[$], r_cyc[$], r_cos[$];
        logic [NREQ-1:0] g_bit[$], r_bit[$];
        int first_rst, rst_cnt, rcyc;
        logic [NREQ-1:0] exp_bits[4];

        v[0] = '{32'd0,          0, 1'b0, 268435456, 0,          28};
        v[1] = '{32'd210828714,  1, 1'b0, 189812531, 189812531,  28};
        v[2] = '{32'h20000000,   0, 1'b1, 0,         0,          1};
        v[3] = '{32'd421657428,  1, 1'b0, 0,         268435456,  28};
        v[4] = '{-32'sd421657428, 0, 1'b0, 0,        -268435456, 28};
        v[5] = '{32'd421657429,  1, 1'b1, 0,         0,          1};
        v[6] = '{32'h80000000,   0, 1'b1, 0,         0,          1};
        v[7] = '{-32'sd210828714, 1, 1'b0, 189812531, -189812531, 28};

        do_reset();
        #1 chk_quiet("reset");
        chk("reset_eng_rst_low", 64'(eng_rst), 64'd0);

        // A done pulse while idle must not wake the scheduler.
        any = 1'b0;
        stray = 1'b1;
        repeat (5) begin
            @(negedge clk);
            any |= (rsp_valid != '0) | eng_clk_en;
        end
        stray = 1'b0;
        chk("stray_done_ignored", 64'(any), 64'd0);

        for (int i = 0; i < 8; i++)
            run_one($sformatf("v%0d", i), v[i].id, v[i].ang, v[i].err, v[i].c, v[i].s, v[i].lat);

        // Both requesters held valid: strict alternation, next grant right after RESP.
        do_reset();
        @(negedge clk);
        req_angle = {32'd210828714, 32'd0};
        req_valid = 2'b11;
        for (int c = 0; c < 116; c++) begin
            #1;
            if (req_ready != '0) begin g_bit.push_back(req_ready); g_cyc.push_back(c); end
            if (rsp_valid != '0) begin
                r_bit.push_back(rsp_valid);
                r_cyc.push_back(c);
                r_cos.push_back($signed(rsp_cos));
            end
            if (c == 115) req_valid = '0;
            @(negedge clk);
        end
        exp_bits = '{2'b01, 2'b10, 2'b01, 2'b10};
        chk("rr_grant_count", 64'(g_cyc.size()), 64'd4);
        chk("rr_rsp_count", 64'(r_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d_bits", i), 64'(i < g_bit.size() ? g_bit[i] : 2'b00), 64'(exp_bits[i]));
            chk($sformatf("rr_grant%0d_cycle", i), 64'(i < g_cyc.size() ? g_cyc[i] : -1), 64'(29 * i));
            chk($sformatf("rr_rsp%0d_bits", i), 64'(i < r_bit.size() ? r_bit[i] : 2'b00), 64'(exp_bits[i]));
            chk($sformatf("rr_rsp%0d_cycle", i), 64'(i < r_cyc.size() ? r_cyc[i] : -1), 64'(29 * i + 28));
        end
        chk_near("rr_req1_cos", r_cos.size() > 1 ? r_cos[1] : 0, 189812531);

        // Engine that never finishes: abort 64 cycles after ROT_WAIT entry (cycle 2).
        @(negedge clk);
        stub = 1'b1;
        req_angle[31:0] = 32'd0;
        req_valid = 2'b01;
        #1 chk("to_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        first_rst = -1;
        rst_cnt = 0;
        rcyc = -1;
        for (int c = 1; c < 200 && rcyc < 0; c++) begin
            if (eng_rst && first_rst < 0) first_rst = c;
            if (eng_rst) rst_cnt++;
            if (rsp_valid != '0) rcyc = c;
            else @(negedge clk);
        end
        chk("to_abort_cycle", 64'(first_rst), 64'd66);
        chk("to_rst_pulses", 64'(rst_cnt), 64'd1);
        chk("to_rsp_cycle", 64'(rcyc), 64'd67);
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_cos", 64'(rsp_cos), 64'd0);
        chk("to_sin", 64'(rsp_sin), 64'd0);
        stub = 1'b0;
        run_one("after_to", 0, 32'd0, 1'b0, 268435456, 0, 28);

        // Reset at cycle 10 of a transaction: silent abort, then a clean transaction.
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        @(negedge clk);
        req_valid = '0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 64'(eng_clk_en), 64'd1);
        reset = 1'b1;
        #1 chk_quiet("mid_rst");
        chk("mid_rst_eng_rst", 64'(eng_rst), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        any = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any |= (rsp_valid != '0);
        end
        chk("mid_no_rsp", 64'(any), 64'd0);
        run_one("after_rst", 1, 32'd210828714, 1'b0, 189812531, 189812531, 28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler that shares one CORDIC sine/cosine engine (custom-instruction style: start/n/dataa → done/result) between NREQ requesters. Per request it range-checks the angle, sequences the engine's three operations (rotate, read X, read Y) and returns cos/sin to the winning requester. It sits between the engine and the requester masters, for example a Nios custom-instruction mux or hardware DSP clients.

## Interface
- NREQ, 2: number of requesters, 2..8.
- TIMEOUT_CYC, 64: maximum cycles spent waiting for one engine `done` before aborting.
- ANGLE_MAX, 421657428: |angle| limit, π/2 in Q4.28.
- clk  in  1  clock; reset reset, asynchronous, active-high (clk, reset)
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester request; held until accepted
- req_angle  in  32*NREQ  signed Q4.28 angle, slice i belongs to requester i
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot, 1-cycle response strobe
- rsp_cos  out  32  signed Q4.28 cosine; valid with rsp_valid
- rsp_sin  out  32  signed Q4.28 sine; valid with rsp_valid
- rsp_err  out  1  1 = range or timeout error; cos/sin are 0
- eng_clk_en  out  1  engine clock enable
- eng_rst  out  1  engine synchronous reset
- eng_start  out  1  engine start pulse
- eng_n  out  8  engine op: 0 = rotate, 1 = read X, 2 = read Y
- eng_dataa  out  32  angle for rotate; 0 otherwise
- eng_done  in  1  engine completion; combinational from engine state
- eng_result  in  32  engine result; valid while eng_done

## Operation
- States:
  - IDLE → ROT_ISSUE → ROT_WAIT → RDX_ISSUE → RDX_WAIT → RDY_ISSUE → RDY_WAIT → RESP → IDLE.
  - Range failure goes IDLE → RESP.
  - Timeout goes from any *_WAIT → ABORT → RESP.
- IDLE:
  - If any req_valid is set, the round-robin pick starts at (last_grant+1) mod NREQ.
  - The pick's req_ready pulses for 1 cycle; its angle and id are latched and last_grant is updated.
  - If |angle| > ANGLE_MAX, go to RESP with err=1 and do not touch the engine.
- *_ISSUE: eng_start=1 for exactly one cycle, with eng_n set to the op and eng_dataa = angle only for rotate.
- *_WAIT:
  - Hold eng_start=0 and wait for eng_done.
  - In RDX_WAIT, latch eng_result into cos; in RDY_WAIT, latch it into sin.
  - The done seen in ROT_WAIT carries no data.
- ABORT: eng_rst=1 for 1 cycle to flush the engine; cos and sin are cleared and err=1.
- RESP:
  - rsp_valid[id]=1 for 1 cycle; the cos/sin/err buses hold until the next RESP.
  - Back to IDLE; no new grant in the same cycle.
- eng_clk_en = (state != IDLE); in IDLE the engine is frozen.
- eng_rst = reset | abort_pulse.
- Timeout counter:
  - 8-bit, cleared on entry to each *_WAIT.
  - When it reaches TIMEOUT_CYC−1 without eng_done, go to ABORT.
  - If eng_done arrives in that same cycle, eng_done wins.
- Boundaries:
  - A requester dropping req_valid before ready is legal and is simply not granted.
  - A stray eng_done outside a *_WAIT is ignored.
  - |angle| == ANGLE_MAX is accepted.
  - The most negative angle, 0x80000000, is rejected; take its magnitude in 33 bits.

## Timing
- Reset values (async): state=IDLE, last_grant=NREQ−1 (so requester 0 wins first), req_ready=0, rsp_valid=0, rsp_cos/rsp_sin=0, rsp_err=0, eng_start=0, eng_n=0, eng_dataa=0, eng_clk_en=0; eng_rst=1 while reset is high.
- Reset mid-operation aborts the transaction silently (no response) and also resets the engine.
- Against the team core (rotate done 22 cycles after start, read done 1 cycle after start), with grant at cycle 0:
  - ROT_ISSUE at cycle 1, rotate done at 23.
  - RDX_ISSUE at 24, done at 25.
  - RDY_ISSUE at 26, done at 27.
  - RESP at 28, giving 28 cycles from grant to rsp_valid.
- Range-error response: rsp_valid at cycle 1 after grant.
- Throughput: one transaction in flight; the next grant comes at the earliest in the cycle after RESP.

## Structure
- Package cordic_sched_pkg holds:
  - the state enum;
  - op constants OP_ROT=0, OP_RDX=1, OP_RDY=2;
  - ANGLE_PI_2 = 421657428 and the Q4.28 one = 268435456;
  - the timeout counter width.
- Sub-module rr_arbiter (NREQ): request vector, enable, last-grant pointer → one-hot grant and encoded index.
- The FSM, timeout counter and result latches live in cordic_sched itself.

## Test plan
- Single request, angle 0, with the real engine: req_ready at cycle 0, rsp_valid at 28, cos=268435456 ±1024, sin=0 ±1024, err=0.
- Angle 210828714 (π/4): cos = sin = 189812531 ±1024.
- Angle 0x20000000 (out of range): rsp_valid 1 cycle after grant with err=1, cos=sin=0, and eng_start never asserted.
- Both requesters valid continuously: grants alternate 0,1,0,1, each response routed to the correct rsp_valid bit, and the second grant comes in the cycle after the first RESP.
- Stub engine that never asserts done, TIMEOUT_CYC=64: ABORT occurs 64 cycles after ROT_WAIT entry, followed by a 1-cycle eng_rst pulse and then rsp_valid with err=1; the next request then completes normally.
- Reset asserted at cycle 10 of a transaction: all outputs return to their reset values immediately, no rsp_valid is produced, and a new request after release completes in 28 cycles.
